wd_multichannel: RTL and testbench

Parametrised successor of the single-channel windowed watchdog. It monitors NCH independent software tasks, each with its own closed/open service window and its own key-protected service register. Per-channel failures latch a sticky fail flag and a 2-bit cause code, and trigger one shared, retriggerable reset pulse. The block sits on the same ABUS/DBUS write bus as the configuration register and drives the board reset request.

---
 rtl/wd_pkg.sv | 22 ++
 rtl/wd_channel.sv | 94 +++++++++
 rtl/wd_multichannel.sv | 67 ++++++
 tb/tb_wd_multichannel.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// Shared definitions for the multichannel windowed watchdog:
// fault cause codes, register offsets within a channel and the default service key.
package wd_pkg;

    // Per-channel fault cause, as reported on FLSTAT.
    typedef enum logic [1:0] {
        FL_NONE    = 2'b00,
        FL_EARLY   = 2'b01,
        FL_TIMEOUT = 2'b10,
        FL_BADKEY  = 2'b11
    } fl_code_e;

    // Register offsets in the low two address bits.
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_SWLEN   = 2'd1;
    localparam logic [1:0] REG_FWLEN   = 2'd2;
    localparam logic [1:0] REG_SERVICE = 2'd3;

    // Default value that must be written to SERVICE to kick a channel.
    localparam logic [15:0] WD_KEY = 16'hA5C3;

endpackage

// File: rtl/wd_channel.sv
// One watchdog channel: enable flag, window lengths, window counter,
// fault detector and sticky fail/cause status. CW must not exceed 16,
// the lengths are taken from the low CW bits of the 16-bit write data.
module wd_channel
    import wd_pkg::*;
#(
    parameter int          CW  = 16,
    parameter logic [15:0] KEY = WD_KEY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_ctrl,
    input  logic        wr_swlen,
    input  logic        wr_fwlen,
    input  logic        wr_service,
    input  logic [15:0] wdata,
    output logic        fail,
    output logic [1:0]  code,
    output logic        fault
);

    logic          en;
    logic [CW-1:0] swlen;
    logic [CW-1:0] fwlen;
    logic [CW-1:0] cnt;
    fl_code_e      fault_code;
    logic          svc_ok;
    logic          enable_ok;

    // Fault detection: a service write outranks the timeout check, so a
    // good key at count FWLEN-1 is a valid service rather than a timeout.
    always_comb begin
        fault      = 1'b0;
        fault_code = FL_NONE;
        svc_ok     = 1'b0;
        if (en) begin
            if (wr_service) begin
                if (wdata != KEY) begin
                    fault      = 1'b1;
                    fault_code = FL_BADKEY;
                end else if (cnt < swlen) begin
                    fault      = 1'b1;
                    fault_code = FL_EARLY;
                end else begin
                    svc_ok = 1'b1;
                end
            end else if (cnt == fwlen - CW'(1)) begin
                fault      = 1'b1;
                fault_code = FL_TIMEOUT;
            end
        end
    end

    // A degenerate window (no open phase) cannot be enabled.
    assign enable_ok = wdata[0] && (swlen < fwlen) && (fwlen != '0);

    // Enable, counter and sticky status; a fault beats a same-cycle CTRL write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= 1'b0;
            cnt  <= '0;
            fail <= 1'b0;
            code <= FL_NONE;
        end else if (fault) begin
            en   <= 1'b0;
            cnt  <= '0;
            fail <= 1'b1;
            code <= fault_code;
        end else begin
            if (wr_ctrl) begin
                if (wdata[1]) begin
                    fail <= 1'b0;
                    code <= FL_NONE;
                end
                en  <= enable_ok;
                cnt <= '0;
            end else if (en) begin
                cnt <= svc_ok ? '0 : cnt + CW'(1);
            end
        end
    end

    // Window lengths are frozen while the channel runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swlen <= '0;
            fwlen <= '1;
        end else if (!en) begin
            if (wr_swlen) swlen <= wdata[CW-1:0];
            if (wr_fwlen) fwlen <= wdata[CW-1:0];
        end
    end

endmodule

// File: rtl/wd_multichannel.sv
// Multichannel windowed watchdog: decodes {channel, reg} writes onto NCH
// channels and stretches any channel fault into one retriggerable reset pulse.
module wd_multichannel
    import wd_pkg::*;
#(
    parameter int          NCH    = 4,
    parameter int          CW     = 16,
    parameter logic [15:0] KEY    = WD_KEY,
    parameter int          RSTLEN = 64,
    localparam int         AW     = $clog2(NCH) + 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WREN,
    input  logic [AW-1:0]    ABUS,
    input  logic [15:0]      DBUS,
    output logic [NCH-1:0]   WDFAIL,
    output logic [2*NCH-1:0] FLSTAT,
    output logic             RSTOUT
);

    localparam int PW = $clog2(RSTLEN + 1);

    logic [AW-1:0]  ch_sel;
    logic [1:0]     reg_sel;
    logic [NCH-1:0] fault_vec;
    logic [PW-1:0]  pulse_cnt;

    assign ch_sel  = ABUS >> 2;
    assign reg_sel = ABUS[1:0];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        assign hit = WREN && (ch_sel == AW'(i));

        wd_channel #(
            .CW  (CW),
            .KEY (KEY)
        ) u_ch (
            .clk        (CLK),
            .rst_n      (RST),
            .wr_ctrl    (hit && (reg_sel == REG_CTRL)),
            .wr_swlen   (hit && (reg_sel == REG_SWLEN)),
            .wr_fwlen   (hit && (reg_sel == REG_FWLEN)),
            .wr_service (hit && (reg_sel == REG_SERVICE)),
            .wdata      (DBUS),
            .fail       (WDFAIL[i]),
            .code       (FLSTAT[2*i +: 2]),
            .fault      (fault_vec[i])
        );
    end

    // Reset pulse stretcher: any fault reloads the full length, so the pulse
    // ends RSTLEN cycles after the most recent fault.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pulse_cnt <= '0;
        end else if (|fault_vec) begin
            pulse_cnt <= PW'(RSTLEN);
        end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PW'(1);
        end
    end

    assign RSTOUT = (pulse_cnt != '0);

endmodule

// File: tb/tb_wd_multichannel.sv
// Directed bench for wd_multichannel with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wd_multichannel;
    import wd_pkg::*;

    localparam int NCH = 4;
    localparam int AW  = 4;

    logic           CLK;
    logic           RST;
    logic           WREN;
    logic [AW-1:0]  ABUS;
    logic [15:0]    DBUS;
    logic [NCH-1:0] WDFAIL;
    logic [7:0]     FLSTAT;
    logic           RSTOUT;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hi;

    wd_multichannel #(
        .NCH    (NCH),
        .CW     (16),
        .KEY    (16'hA5C3),
        .RSTLEN (64)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .WREN   (WREN),
        .ABUS   (ABUS),
        .DBUS   (DBUS),
        .WDFAIL (WDFAIL),
        .FLSTAT (FLSTAT),
        .RSTOUT (RSTOUT)
    );

    // Clock generation.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point for every check.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus write, sampled by the next rising edge; returns on the following falling edge.
    task automatic bus_write(input int ch, input logic [1:0] rg, input logic [15:0] d);
        logic [1:0] c;
        c = 2'(ch);
        @(negedge CLK);
        WREN = 1'b1;
        ABUS = {c, rg};
        DBUS = d;
        @(negedge CLK);
        WREN = 1'b0;
        ABUS = '0;
        DBUS = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Length of the current RSTOUT pulse in cycles, counting the present one.
    task automatic measure_pulse(output int n);
        n = 0;
        while (RSTOUT === 1'b1 && n < 300) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // Bounded wait for the reset pulse to finish.
    task automatic drain_pulse();
        int n;
        measure_pulse(n);
        check("pulse_drain", 32'(RSTOUT), 32'd0);
    endtask

    initial begin
        int lows;
        WREN = 1'b0;
        ABUS = '0;
        DBUS = '0;
        RST  = 1'b0;
        idle(3);
        check("rst_wdfail", 32'(WDFAIL), 32'd0);
        check("rst_flstat", 32'(FLSTAT), 32'd0);
        check("rst_rstout", 32'(RSTOUT), 32'd0);
        RST = 1'b1;
        idle(2);

        // ch0: five good services at count 12 inside window [10,19].
        bus_write(0, REG_SWLEN, 16'd10);
        bus_write(0, REG_FWLEN, 16'd20);
        bus_write(0, REG_CTRL, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            idle(11);
            bus_write(0, REG_SERVICE, 16'hA5C3);
        end
        check("t1_wdfail", 32'(WDFAIL), 32'd0);
        check("t1_rstout", 32'(RSTOUT), 32'd0);
        bus_write(0, REG_CTRL, 16'h0000);

        // ch1: good key at count 5 is early.
        bus_write(1, REG_SWLEN, 16'd10);
        bus_write(1, REG_FWLEN, 16'd20);
        bus_write(1, REG_CTRL, 16'h0001);
        idle(4);
        bus_write(1, REG_SERVICE, 16'hA5C3);
        check("t2_wdfail", 32'(WDFAIL), 32'b0010);
        check("t2_flstat1", 32'(FLSTAT[3:2]), 32'(FL_EARLY));
        measure_pulse(n_hi);
        check("t2_pulse_len", 32'(n_hi), 32'd64);

        // ch2: unserviced channel times out at count 19.
        bus_write(2, REG_SWLEN, 16'd10);
        bus_write(2, REG_FWLEN, 16'd20);
        bus_write(2, REG_CTRL, 16'h0001);
        idle(19);
        check("t3_before_to", 32'(WDFAIL[2]), 32'd0);
        idle(1);
        check("t3_to_fail", 32'(WDFAIL[2]), 32'd1);
        check("t3_to_code", 32'(FLSTAT[5:4]), 32'(FL_TIMEOUT));
        check("t3_to_rstout", 32'(RSTOUT), 32'd1);
        // Separate run: service exactly at count 19 beats the timeout.
        bus_write(2, REG_CTRL, 16'h0002);
        check("t3_clear", 32'(WDFAIL[2]), 32'd0);
        bus_write(2, REG_CTRL, 16'h0001);
        idle(18);
        bus_write(2, REG_SERVICE, 16'hA5C3);
        check("t3_edge_svc", 32'(WDFAIL[2]), 32'd0);
        idle(19);
        check("t3_restart", 32'(WDFAIL[2]), 32'd0);
        bus_write(2, REG_CTRL, 16'h0002);
        drain_pulse();

        // ch3: wrong key while enabled, then CLEAR.
        bus_write(3, REG_CTRL, 16'h0001);
        bus_write(3, REG_SERVICE, 16'h1234);
        check("t4_fail", 32'(WDFAIL[3]), 32'd1);
        check("t4_code", 32'(FLSTAT[7:6]), 32'(FL_BADKEY));
        check("t4_rstout", 32'(RSTOUT), 32'd1);
        bus_write(3, REG_CTRL, 16'h0002);
        check("t4_clr_fail", 32'(WDFAIL[3]), 32'd0);
        check("t4_clr_code", 32'(FLSTAT[7:6]), 32'd0);
        drain_pulse();
        bus_write(3, REG_SERVICE, 16'h1234);
        check("t4_dis_svc_fail", 32'(WDFAIL[3]), 32'd0);
        check("t4_dis_svc_rst", 32'(RSTOUT), 32'd0);

        // ch0 and ch1 time out together, ch2 faults 30 cycles later.
        bus_write(1, REG_CTRL, 16'h0002);
        bus_write(0, REG_FWLEN, 16'd22);
        bus_write(2, REG_FWLEN, 16'd1000);
        bus_write(2, REG_CTRL, 16'h0001);
        bus_write(0, REG_CTRL, 16'h0001);
        bus_write(1, REG_CTRL, 16'h0001);
        idle(19);
        check("t5_before", 32'(WDFAIL), 32'd0);
        idle(1);
        check("t5_both_fail", 32'(WDFAIL), 32'b0011);
        check("t5_codes", 32'(FLSTAT[3:0]), 32'b1010);
        lows = 0;
        for (int i = 0; i < 28; i++) begin
            if (RSTOUT !== 1'b1) lows++;
            @(negedge CLK);
        end
        check("t5_pulse_gap", 32'(lows), 32'd0);
        bus_write(2, REG_SERVICE, 16'h0BAD);
        check("t5_all_fail", 32'(WDFAIL), 32'b0111);
        check("t5_code2", 32'(FLSTAT[5:4]), 32'(FL_BADKEY));
        measure_pulse(n_hi);
        check("t5_retrig_len", 32'(n_hi), 32'd64);

        // ch3: degenerate window rejected, lengths frozen while enabled.
        bus_write(3, REG_SWLEN, 16'd20);
        bus_write(3, REG_FWLEN, 16'd20);
        bus_write(3, REG_CTRL, 16'h0001);
        idle(25);
        bus_write(3, REG_SERVICE, 16'h1234);
        check("t6_rejected", 32'(WDFAIL[3]), 32'd0);
        bus_write(3, REG_FWLEN, 16'd30);
        bus_write(3, REG_CTRL, 16'h0001);
        bus_write(3, REG_FWLEN, 16'd100);
        idle(27);
        check("t6_fw_frozen_pre", 32'(WDFAIL[3]), 32'd0);
        idle(1);
        check("t6_fw_frozen", 32'(WDFAIL[3]), 32'd1);
        check("t6_code", 32'(FLSTAT[7:6]), 32'(FL_TIMEOUT));

        // Asynchronous reset in the middle of the pulse.
        idle(5);
        check("t7_pulse_on", 32'(RSTOUT), 32'd1);
        #1 RST = 1'b0;
        #1;
        check("t7_rstout", 32'(RSTOUT), 32'd0);
        check("t7_wdfail", 32'(WDFAIL), 32'd0);
        check("t7_flstat", 32'(FLSTAT), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        // Lengths back at reset values: SWLEN 0 lets a service at count 1 pass.
        bus_write(3, REG_CTRL, 16'h0001);
        bus_write(3, REG_SERVICE, 16'hA5C3);
        check("t7_len_reset", 32'(WDFAIL), 32'd0);
        check("t7_no_pulse", 32'(RSTOUT), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
